// File: rtl/mode_pkg.sv
// Shared encodings for the button/mode path: FSM states and
// mode indices, plus a small width helper.
package mode_pkg;

  typedef enum logic [1:0] {
    ST_GAP = 2'd0,
    ST_ON  = 2'd1,
    ST_OFF = 2'd2,
    ST_ACK = 2'd3
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NONE  = 2'd0;
  localparam mode_t MODE_HFILT = 2'd1;
  localparam mode_t MODE_VFILT = 2'd2;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mode_led_tick_gen.sv
// tick_gen: prescaler 0..c_max with synchronous clear; o_tick is
// high for the one clk the count sits at c_max.
// Ports: clk, rst_n, i_clr (sync clear), o_tick (pulse).
module tick_gen #(
  parameter int unsigned      c_w   = 24,
  parameter logic [c_w-1:0]   c_max = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_w'(1);
    end
  end

  assign o_tick = (r_cnt == c_max);

endmodule

// File: rtl/mode_led.sv
// mode_led: shows filter mode as a 0/1/2-blink code, test mode as a
// steady LED and any mode change as an acknowledge flash.
// Ports: clk, rst_n (async, low), filter_on, vfilter, test_mode in;
// led_code, led_test, led_ack out. Optional MODE_LED_DIM_EN gives
// 25 % duty on led_code/led_test via a free-running 2-bit counter.
module mode_led
  import mode_pkg::*;
#(
  parameter logic              c_on        = 1'b1,
  parameter int unsigned       c_tick_w    = 24,
  parameter logic [c_tick_w-1:0] c_tick_max = 24'd4_999_999,
  parameter int                c_on_ticks  = 4,
  parameter int                c_off_ticks = 4,
  parameter int                c_gap_ticks = 16,
  parameter int                c_ack_ticks = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic filter_on,
  input  logic vfilter,
  input  logic test_mode,
  output logic led_code,
  output logic led_test,
  output logic led_ack
);

  localparam int c_max_t =
    max4(c_on_ticks, c_off_ticks, c_gap_ticks, c_ack_ticks);
  localparam int c_ph_w =
    (c_max_t > 1) ? $clog2(c_max_t) : 1;

  localparam logic [c_ph_w-1:0] c_on_last  =
    c_ph_w'(c_on_ticks - 1);
  localparam logic [c_ph_w-1:0] c_off_last =
    c_ph_w'(c_off_ticks - 1);
  localparam logic [c_ph_w-1:0] c_gap_last =
    c_ph_w'(c_gap_ticks - 1);
  localparam logic [c_ph_w-1:0] c_ack_last =
    c_ph_w'(c_ack_ticks - 1);

  state_t            r_state;
  logic [c_ph_w-1:0] r_phase;
  logic [1:0]        r_blink;
  mode_t             r_k_q;
  logic              r_test_q;

  mode_t w_k;
  logic  w_chg;
  logic  w_tick;
  logic  w_dim;

  always_comb begin
    w_k = MODE_NONE;
    unique case (1'b1)
      (!filter_on):            w_k = MODE_NONE;
      (filter_on && !vfilter): w_k = MODE_HFILT;
      (filter_on && vfilter):  w_k = MODE_VFILT;
      default:                 w_k = MODE_NONE;
    endcase
  end

  // vfilter is folded into k only when filter_on, so toggling it
  // with the filter off never counts as a change.
  assign w_chg = ({w_k, test_mode} != {r_k_q, r_test_q});

  // Prescaler restarts on a change so ACK always has full length.
  tick_gen #(
    .c_w   (c_tick_w),
    .c_max (c_tick_max)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_chg),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_GAP;
      r_phase  <= '0;
      r_blink  <= '0;
      r_k_q    <= MODE_NONE;
      r_test_q <= 1'b0;
    end else begin
      r_k_q    <= w_k;
      r_test_q <= test_mode;
      if (w_chg) begin
        r_state <= ST_ACK;
        r_phase <= '0;
        r_blink <= '0;
      end else if (w_tick) begin
        unique case (r_state)
          ST_GAP: begin
            if (r_phase == c_gap_last) begin
              r_phase <= '0;
              r_blink <= '0;
              if (r_k_q != MODE_NONE) begin
                r_state <= ST_ON;
              end else begin
                r_state <= ST_GAP;
              end
            end else begin
              r_phase <= r_phase + c_ph_w'(1);
            end
          end
          ST_ON: begin
            if (r_phase == c_on_last) begin
              r_phase <= '0;
              r_blink <= r_blink + 2'd1;
              r_state <= ST_OFF;
            end else begin
              r_phase <= r_phase + c_ph_w'(1);
            end
          end
          ST_OFF: begin
            if (r_phase == c_off_last) begin
              r_phase <= '0;
              if (r_blink < r_k_q) begin
                r_state <= ST_ON;
              end else begin
                r_state <= ST_GAP;
              end
            end else begin
              r_phase <= r_phase + c_ph_w'(1);
            end
          end
          ST_ACK: begin
            if (r_phase == c_ack_last) begin
              r_phase <= '0;
              r_state <= ST_GAP;
            end else begin
              r_phase <= r_phase + c_ph_w'(1);
            end
          end
          default: begin
            r_phase <= '0;
            r_state <= ST_GAP;
          end
        endcase
      end
    end
  end

`ifdef MODE_LED_DIM_EN
  logic [1:0] r_dim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dim <= 2'd0;
    end else begin
      r_dim <= r_dim + 2'd1;
    end
  end

  assign w_dim = (r_dim == 2'd0);
`else
  assign w_dim = 1'b1;
`endif

  // Pure decodes of registered state; no input reaches a pin.
  assign led_code =
    ((r_state == ST_ON) && w_dim) ? c_on : ~c_on;
  assign led_ack =
    (r_state == ST_ACK) ? c_on : ~c_on;
  assign led_test =
    (r_test_q && w_dim) ? c_on : ~c_on;

endmodule
